// File: rtl/parking_pkg.sv
// Shared types and constants for the parking lot gate controller.
// Imported by the top module and the synchronizer.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    IN_A       = 3'd1,
    IN_AB      = 3'd2,
    IN_B       = 3'd3,
    OUT_B      = 3'd4,
    OUT_AB     = 3'd5,
    OUT_A      = 3'd6,
    WAIT_CLEAR = 3'd7
  } state_t;

  localparam int   DEFAULT_CAPACITY = 25;
  localparam logic SENSOR_BLOCKED   = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one raw asynchronous sensor line.
// Async active-high reset clears both stages.
module sync_2ff
  import parking_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/parking_lot_controller.sv
// Gate passage decoder and saturating occupancy counter.
// Pulses enter/exit on a completed car passage.
module parking_lot_controller
  import parking_pkg::*;
#(
  parameter int CAPACITY = DEFAULT_CAPACITY,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  output logic             enter,
  output logic             exit,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

  logic   a_s;
  logic   b_s;
  logic [1:0] ab;
  state_t state;

  sync_2ff u_sync_a (
    .clk   (clk),
    .reset (reset),
    .d     (a),
    .q     (a_s)
  );

  sync_2ff u_sync_b (
    .clk   (clk),
    .reset (reset),
    .d     (b),
    .q     (b_s)
  );

  assign ab = {a_s == SENSOR_BLOCKED,
               b_s == SENSOR_BLOCKED};

  // Each state's own ab pattern is the hold case.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      enter <= 1'b0;
      exit  <= 1'b0;
      count <= '0;
    end else begin
      enter <= 1'b0;
      exit  <= 1'b0;
      unique case (state)
        IDLE:
          unique case (ab)
            2'b10:   state <= IN_A;
            2'b01:   state <= OUT_B;
            2'b11:   state <= WAIT_CLEAR;
            default: state <= IDLE;
          endcase
        IN_A:
          unique case (ab)
            2'b11:   state <= IN_AB;
            2'b00:   state <= IDLE;
            2'b01:   state <= WAIT_CLEAR;
            default: state <= IN_A;
          endcase
        IN_AB:
          unique case (ab)
            2'b01:   state <= IN_B;
            2'b10:   state <= IN_A;
            2'b00:   state <= WAIT_CLEAR;
            default: state <= IN_AB;
          endcase
        IN_B:
          unique case (ab)
            2'b00: begin
              state <= IDLE;
              enter <= 1'b1;
              if (count != CAP)
                count <= count + 1'b1;
            end
            2'b11:   state <= IN_AB;
            2'b10:   state <= WAIT_CLEAR;
            default: state <= IN_B;
          endcase
        OUT_B:
          unique case (ab)
            2'b11:   state <= OUT_AB;
            2'b00:   state <= IDLE;
            2'b10:   state <= WAIT_CLEAR;
            default: state <= OUT_B;
          endcase
        OUT_AB:
          unique case (ab)
            2'b10:   state <= OUT_A;
            2'b01:   state <= OUT_B;
            2'b00:   state <= WAIT_CLEAR;
            default: state <= OUT_AB;
          endcase
        OUT_A:
          unique case (ab)
            2'b00: begin
              state <= IDLE;
              exit  <= 1'b1;
              if (count != '0)
                count <= count - 1'b1;
            end
            2'b11:   state <= OUT_AB;
            2'b01:   state <= WAIT_CLEAR;
            default: state <= OUT_A;
          endcase
        WAIT_CLEAR:
          if (ab == 2'b00)
            state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign full  = (count == CAP);
  assign empty = (count == '0);

endmodule

// File: tb/tb_parking_lot_controller.sv
// Randomized and directed bench against a position-walk model.
// Model tracks car position along the gate, not FSM states.
module tb_parking_lot_controller;

  localparam int CAP = 25;

  logic       clk = 1'b0;
  logic       reset;
  logic       a;
  logic       b;
  logic       enter;
  logic       exit;
  logic [4:0] count;
  logic       full;
  logic       empty;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ent   = 0;
  int n_ext   = 0;

  // model: mode 0 idle, 1 entering, 2 exiting, 3 blocked
  int   m_mode;
  int   m_pos;
  int   m_cnt;
  bit   m_enter;
  bit   m_exit;
  logic [1:0] h0;
  logic [1:0] h1;

  parking_lot_controller #(
    .CAPACITY (CAP),
    .CNT_W    (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .enter (enter),
    .exit  (exit),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input int got,
                       input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int pos_of(input logic [1:0] v);
    case (v)
      2'b10:   return 1;
      2'b11:   return 2;
      2'b01:   return 3;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_pos   = 0;
    m_cnt   = 0;
    m_enter = 0;
    m_exit  = 0;
    h0      = 2'b00;
    h1      = 2'b00;
  endtask

  // A car walks positions 1..3 one step at a time; skipping blocks.
  task automatic model_step(input logic [1:0] v);
    int p;
    m_enter = 0;
    m_exit  = 0;
    p = pos_of(v);
    case (m_mode)
      0: begin
        if (v == 2'b10) begin m_mode = 1; m_pos = 1; end
        else if (v == 2'b01) begin m_mode = 2; m_pos = 3; end
        else if (v == 2'b11) m_mode = 3;
      end
      1, 2: begin
        if (v == 2'b00) begin
          if (m_mode == 1 && m_pos == 3) begin
            m_enter = 1;
            if (m_cnt < CAP) m_cnt++;
          end else if (m_mode == 2 && m_pos == 1) begin
            m_exit = 1;
            if (m_cnt > 0) m_cnt--;
          end
          m_mode = (m_pos == 2) ? 3 : 0;
        end else if (p == m_pos + 1 || p == m_pos - 1) begin
          m_pos = p;
        end else if (p != m_pos) begin
          m_mode = 3;
        end
      end
      default: if (v == 2'b00) m_mode = 0;
    endcase
  endtask

  task automatic step(input logic [1:0] nab);
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      model_step(h1);
      h1 = h0;
      h0 = {a, b};
    end
    #1 {a, b} = nab;
    @(negedge clk);
    check("enter", enter, m_enter);
    check("exit", exit, m_exit);
    check("count", count, m_cnt);
    check("full", full, m_cnt == CAP);
    check("empty", empty, m_cnt == 0);
    n_ent += int'(enter);
    n_ext += int'(exit);
  endtask

  task automatic hold(input logic [1:0] v, input int n);
    repeat (n) step(v);
  endtask

  task automatic seq(input logic [1:0] s[$]);
    foreach (s[i]) hold(s[i], 4);
    hold(2'b00, 6);
  endtask

  task automatic do_entry();
    logic [1:0] s[$];
    s = {2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    seq(s);
  endtask

  task automatic do_exit();
    logic [1:0] s[$];
    s = {2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
    seq(s);
  endtask

  initial begin
    logic [1:0] s[$];
    logic [1:0] cur;
    int e0;
    int x0;
    reset = 1'b1;
    a = 1'b0;
    b = 1'b0;
    model_reset();
    #12;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_enter", enter, 0);
    check("rst_exit", exit, 0);
    @(negedge clk);
    reset = 1'b0;

    e0 = n_ent;
    do_entry();
    check("entry_pulses", n_ent - e0, 1);
    check("entry_count", count, 1);

    x0 = n_ext;
    do_exit();
    check("exit_pulses", n_ext - x0, 1);
    check("exit_empty", empty, 1);

    e0 = n_ent;
    s = {2'b10, 2'b11, 2'b10, 2'b00};
    seq(s);
    check("abort_pulses", n_ent - e0, 0);
    s = {2'b10, 2'b11, 2'b01, 2'b11, 2'b01, 2'b00};
    seq(s);
    check("osc_pulses", n_ent - e0, 1);
    check("osc_count", count, 1);

    repeat (24) do_entry();
    check("sat_full", full, 1);
    e0 = n_ent;
    do_entry();
    check("sat_pulse", n_ent - e0, 1);
    check("sat_count", count, CAP);
    repeat (25) do_exit();
    x0 = n_ext;
    do_exit();
    check("floor_pulse", n_ext - x0, 1);
    check("floor_count", count, 0);

    e0 = n_ent;
    x0 = n_ext;
    s = {2'b00, 2'b11, 2'b01, 2'b00};
    seq(s);
    check("illegal_pulses", n_ent + n_ext - e0 - x0, 0);
    do_entry();
    check("post_illegal", count, 1);

    repeat (6) do_entry();
    hold(2'b10, 4);
    hold(2'b11, 4);
    hold(2'b01, 4);
    hold(2'b00, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_enter", enter, 0);
    model_reset();
    {a, b} = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    e0 = n_ent;
    hold(2'b00, 8);
    check("mid_rst_pulse", n_ent - e0, 0);

    cur = 2'b00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 8) begin
        case (cur)
          2'b00: cur = $urandom_range(0, 1) ? 2'b10 : 2'b01;
          2'b10: cur = $urandom_range(0, 1) ? 2'b11 : 2'b00;
          2'b11: cur = $urandom_range(0, 1) ? 2'b01 : 2'b10;
          default: cur = $urandom_range(0, 1) ? 2'b00 : 2'b11;
        endcase
      end else begin
        cur = 2'($urandom_range(0, 3));
      end
      hold(cur, $urandom_range(1, 5));
    end
    hold(2'b00, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/parking_lot_controller.md
Name: parking_lot_controller

Overview:
- Sequences the lot occupancy counter from two gate photo-sensors: a (outer beam) and b (inner beam); 1 = beam blocked.
- Synchronizes the sensors and decodes full car passages with a direction-tracking FSM.
- Emits one-cycle enter/exit pulses and maintains the saturating occupancy count with full/empty flags.
- Sits between the sensor pins and the display/status logic.

Parameters:
- CAPACITY, 25, maximum occupancy; the count saturates here.
- CNT_W, 5, width of count; must satisfy 2**CNT_W > CAPACITY.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- a  input  1  outer sensor, raw and asynchronous; 1 = blocked
- b  input  1  inner sensor, raw and asynchronous; 1 = blocked
- enter  output  1  one-cycle pulse on a completed entry
- exit  output  1  one-cycle pulse on a completed exit
- count  output  CNT_W  current occupancy
- full  output  1  count == CAPACITY
- empty  output  1  count == 0

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset values: all synchronizer flops 0, FSM in IDLE, enter=0, exit=0, count=0, full=0, empty=1.
- Reset mid-sequence abandons the passage. No pulse is generated and count returns to 0.
- Synchronizer: each of a and b passes through a 2-flop synchronizer. FSM input is ab = {a_s, b_s}.
- FSM states: IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A, WAIT_CLEAR.
- IDLE: ab=10 -> IN_A; 01 -> OUT_B; 11 -> WAIT_CLEAR; 00 -> stay.
- IN_A: 11 -> IN_AB; 00 -> IDLE (car backed out, no pulse); 01 -> WAIT_CLEAR.
- IN_AB: 01 -> IN_B; 10 -> IN_A; 00 -> WAIT_CLEAR.
- IN_B: 00 -> IDLE with enter pulse; 11 -> IN_AB; 10 -> WAIT_CLEAR.
- OUT_B: 11 -> OUT_AB; 00 -> IDLE (no pulse); 10 -> WAIT_CLEAR.
- OUT_AB: 10 -> OUT_A; 01 -> OUT_B; 00 -> WAIT_CLEAR.
- OUT_A: 00 -> IDLE with exit pulse; 11 -> OUT_AB; 01 -> WAIT_CLEAR.
- WAIT_CLEAR: 00 -> IDLE; otherwise stay. Never pulses.
- In any state, ab unchanged means stay. Any two-bit jump not listed above goes to WAIT_CLEAR.
- Pulse timing: enter/exit are registered. They are high exactly one cycle, starting at the edge where the FSM returns to IDLE.
- Count update: happens on that same edge, so count shows the new value in the cycle the pulse is high.
- Increment: only if count != CAPACITY. Decrement: only if count != 0. Otherwise count holds.
- The enter/exit pulse still asserts even when the count saturates and holds.
- enter and exit are mutually exclusive by construction.
- Latency: a raw sensor change that completes a passage produces the pulse and count change 3 rising edges later (2 synchronizer edges + 1 FSM edge).
- full and empty are combinational decodes of the count register. They are glitch-free because count is registered.
- Arithmetic: unsigned, CNT_W bits. Saturation guarantees no wrap-around.

Decomposition:
- Package parking_pkg holds:
  - the state_t enum (IDLE..WAIT_CLEAR, 3 bits, explicit encoding);
  - localparam DEFAULT_CAPACITY = 25;
  - localparam SENSOR_BLOCKED = 1'b1.
- Sub-module sync_2ff: a 1-bit two-flop synchronizer with async active-high reset, instantiated twice.
- FSM, pulse registers and count register stay in the top module.

Test Plan:
- Entry: from reset (count=0), drive ab 00->10->11->01->00, each held 4 cycles -> enter high exactly 1 cycle, 3 edges after the final 00; count=1, empty=0.
- Exit: from count=1, drive 00->01->11->10->00 -> exit pulse once; count=0, empty=1.
- Abort and oscillate: drive 10->11->10->00 -> no pulse, count unchanged. Drive 10->11->01->11->01->00 -> exactly one enter.
- Saturation: preload 25 entries (full=1), then perform a 26th entry -> enter pulses, count stays 25, full stays 1. Exit at count=0 -> exit pulses, count stays 0.
- Illegal jump: drive 00->11 -> WAIT_CLEAR, then 01, then 00 -> no pulses, count unchanged. A following legal entry counts normally.
- Reset mid-operation: in IN_B with count=7, assert reset asynchronously (between edges) -> count=0, outputs at reset values immediately. Releasing with ab=00 gives no pulse.
